ofm_writeback: RTL and testbench

- Output-side counterpart of the IFM input unpacker: collects the 8-bit signed OFM samples leaving the accelerator's OFM buffer and packs them four per 32-bit word.
- Writes the packed words to external feature-map memory through a ready/valid write port, at consecutive word addresses starting from a programmed base.
- Signals layer completion to the host/controller with a one-cycle done pulse.

---
 rtl/ofm_writeback.sv | 171 +++++++++++++++++
 tb/tb_ofm_writeback.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_writeback.sv
// ofm_writeback: packs signed 8-bit OFM samples four per 32-bit word and
// writes them to feature-map memory at consecutive word addresses from a
// programmed base. A one-cycle done pulse marks the end of each layer.
module ofm_writeback #(
  parameter int ofm_output_width = 8,
  parameter int mem_data_width   = 32,
  parameter int addr_width       = 16,
  parameter int count_width      = 16,
  localparam int LANES           = mem_data_width / ofm_output_width
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [addr_width-1:0]       base_addr,
  input  logic [count_width-1:0]      num_ofm,
  input  logic                        ofm_valid,
  input  logic [ofm_output_width-1:0] ofm_data,
  output logic                        ofm_ready,
  output logic                        mem_wr_en,
  output logic [addr_width-1:0]       mem_wr_addr,
  output logic [mem_data_width-1:0]   mem_wr_data,
  output logic [LANES-1:0]            mem_wr_be,
  input  logic                        mem_wr_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [LW-1:0]          LANE_ZERO = LW'(0);
  localparam logic [LW-1:0]          LANE_ONE  = LW'(1);
  localparam logic [LW-1:0]          LANE_MAX  = LW'(LANES - 1);
  localparam logic [count_width-1:0] CNT_ZERO  = count_width'(0);
  localparam logic [count_width-1:0] CNT_ONE   = count_width'(1);
  localparam logic [addr_width-1:0]  ADDR_ONE  = addr_width'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  state_e                      state_q, state_d;
  logic [addr_width-1:0]       addr_q, addr_d;
  logic [count_width-1:0]      rem_q, rem_d;
  logic [LW-1:0]               lane_q, lane_d;
  logic [mem_data_width-1:0]   data_q, data_d;
  logic [LANES-1:0]            be_q, be_d;
  logic                        wr_en_q, wr_en_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  // Next-state, datapath updates and registered-output decode for the writeback FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lane_d  = lane_q;
    data_d  = data_q;
    be_d    = be_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d = base_addr;
          rem_d  = num_ofm;
          lane_d = LANE_ZERO;
          data_d = '0;
          be_d   = '0;
          if (num_ofm == CNT_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_COLLECT: begin
        // ofm_ready is high throughout COLLECT, so valid alone means a transfer.
        if (ofm_valid) begin
          for (int i = 0; i < LANES; i++) begin
            if (lane_q == LW'(i)) begin
              data_d[i*ofm_output_width +: ofm_output_width] = ofm_data;
              be_d[i] = 1'b1;
            end else begin
              data_d[i*ofm_output_width +: ofm_output_width] =
                data_q[i*ofm_output_width +: ofm_output_width];
              be_d[i] = be_q[i];
            end
          end
          lane_d = lane_q + LANE_ONE;
          rem_d  = rem_q - CNT_ONE;
          if ((lane_q == LANE_MAX) || (rem_q == CNT_ONE)) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end

      ST_WRITE: begin
        // Address, data and byte enables hold until the memory takes the word.
        if (mem_wr_ready) begin
          addr_d = addr_q + ADDR_ONE;
          data_d = '0;
          be_d   = '0;
          lane_d = LANE_ZERO;
          if (rem_q == CNT_ZERO) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered versions of the upcoming state.
    wr_en_d = (state_d == ST_WRITE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  // State, datapath and registered-output flops; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lane_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lane_q  <= lane_d;
      data_q  <= data_d;
      be_q    <= be_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ofm_ready   = (state_q == ST_COLLECT);
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = data_q;
  assign mem_wr_be   = be_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ofm_writeback.sv
// Self-checking bench for ofm_writeback: a word-level packing model builds the
// expected write stream from each layer's sample list; a compare process
// checks every memory handshake, stall stability and the done pulse.
module tb_ofm_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] num_ofm;
  logic        ofm_valid;
  logic [7:0]  ofm_data;
  logic        ofm_ready;
  logic        mem_wr_en;
  logic [15:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_be;
  logic        mem_wr_ready;
  logic        busy;
  logic        done;

  ofm_writeback dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_ofm(num_ofm), .ofm_valid(ofm_valid), .ofm_data(ofm_data),
    .ofm_ready(ofm_ready), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_be(mem_wr_be),
    .mem_wr_ready(mem_wr_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] stim_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int acc_cnt = 0;
  int last_acc_cyc = 0;
  int stall_cnt = 0;
  bit bp_mode = 1'b0;
  bit prev_done = 1'b0;
  bit held_valid = 1'b0;
  wr_t held;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: pack the sample list four per word, little-endian, zero/be=0 tail.
  task automatic build_exp(input logic [15:0] base, input int n);
    int words;
    words = (n + 3) / 4;
    for (int k = 0; k < words; k++) begin
      wr_t w;
      w.a  = base + 16'(k);
      w.d  = 32'h0;
      w.be = 4'h0;
      for (int i = 0; i < 4; i++) begin
        if (4 * k + i < n) begin
          w.d[8*i +: 8] = stim_q[4*k + i];
          w.be[i] = 1'b1;
        end
      end
      exp_q.push_back(w);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: checks writes against the model and protocol rules.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wr_en) begin
        chk("ready_low_in_write", ofm_ready, 0);
        chk("busy_in_write", busy, 1);
        if (held_valid) begin
          chk("stall_addr_stable", mem_wr_addr, held.a);
          chk("stall_data_stable", mem_wr_data, held.d);
          chk("stall_be_stable", mem_wr_be, held.be);
        end
        if (mem_wr_ready) begin
          held_valid = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", mem_wr_addr, e.a);
            chk("wr_data", mem_wr_data, e.d);
            chk("wr_be", mem_wr_be, e.be);
          end
        end else begin
          held.a  = mem_wr_addr;
          held.d  = mem_wr_data;
          held.be = mem_wr_be;
          held_valid = 1'b1;
          stall_cnt++;
        end
      end else begin
        if (held_valid) chk("write_dropped", 1, 0);
        held_valid = 1'b0;
      end
      if (ofm_valid && ofm_ready) begin
        acc_cnt++;
        last_acc_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_single_cycle", prev_done, 0);
        chk("busy_during_done", busy, 1);
        chk("done_queue_empty", 64'(exp_q.size()), 0);
      end
      prev_done = done;
    end else begin
      held_valid = 1'b0;
      prev_done  = 1'b0;
    end
  end

  // Memory-side ready driver; in backpressure mode each write stalls 5 cycles.
  initial begin
    int stall_left;
    stall_left   = 5;
    mem_wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode && mem_wr_en && stall_left > 0) begin
        mem_wr_ready = 1'b0;
        stall_left--;
      end else begin
        mem_wr_ready = 1'b1;
        if (!mem_wr_en) stall_left = 5;
      end
    end
  end

  // All stimulus tasks start and end at posedge + 1.
  task automatic do_start(input logic [15:0] b, input logic [15:0] n);
    start = 1'b1;
    base_addr = b;
    num_ofm = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int k, input bit spur);
    for (int i = 0; i < k; i++) begin
      bit acc;
      acc = 1'b0;
      ofm_valid = 1'b1;
      ofm_data  = stim_q[i];
      for (int t = 0; t < 50 && !acc; t++) begin
        @(negedge clk);
        if (ofm_ready) acc = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (!acc) begin
        chk("feed_timeout", 0, 1);
        ofm_valid = 1'b0;
        return;
      end
      if (spur && i == 1) begin
        start = 1'b1;
        base_addr = 16'h1234;
        num_ofm = 16'd3;
      end
    end
    ofm_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int a0, input int n);
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (done_cnt > d0) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
    chk("done_count", 64'(done_cnt), 64'(d0 + 1));
    chk("writes_all_seen", 64'(exp_q.size()), 0);
    chk("samples_accepted", 64'(acc_cnt - a0), 64'(n));
    @(posedge clk); #1;
  endtask

  task automatic run_layer(input logic [15:0] b, input int n, input bit spur);
    int d0, a0;
    d0 = done_cnt;
    a0 = acc_cnt;
    do_start(b, 16'(n));
    feed(n, spur);
    wait_done(d0, a0, n);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = 16'h0;
    num_ofm = 16'h0;
    ofm_valid = 1'b0;
    ofm_data = 8'h0;
    #12;
    chk("reset_state",
        {ofm_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be, busy, done}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full words, back-to-back, done latency 2 after last sample.
    stim_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    build_exp(16'h0010, 8);
    chk("pin_full_w0", {exp_q[0].a, exp_q[0].d, exp_q[0].be}, {16'h0010, 32'h04030201, 4'hF});
    chk("pin_full_w1", {exp_q[1].a, exp_q[1].d, exp_q[1].be}, {16'h0011, 32'h08070605, 4'hF});
    run_layer(16'h0010, 8, 1'b0);
    chk("done_latency", 64'(done_cyc - last_acc_cyc), 2);

    // Partial final word with signed samples.
    stim_q = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'h7F, 8'h80};
    build_exp(16'h0020, 6);
    chk("pin_signed_w0", {exp_q[0].d, exp_q[0].be}, {32'hFCFDFEFF, 4'hF});
    chk("pin_partial_w1", {exp_q[1].a, exp_q[1].d, exp_q[1].be}, {16'h0021, 32'h0000807F, 4'h3});
    run_layer(16'h0020, 6, 1'b0);

    // Backpressure: 5 stall cycles on every write.
    stim_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    build_exp(16'h0200, 8);
    stall_cnt = 0;
    bp_mode = 1'b1;
    run_layer(16'h0200, 8, 1'b0);
    bp_mode = 1'b0;
    chk("stall_cycles", 64'(stall_cnt), 10);

    // Zero count: done and busy for exactly the cycle after the start-accept cycle.
    begin
      int d0;
      d0 = done_cnt;
      do_start(16'h0100, 16'd0);
      @(negedge clk);
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 1);
      @(negedge clk);
      chk("zero_done_after", done, 0);
      chk("zero_busy_after", busy, 0);
      chk("zero_done_count", 64'(done_cnt), 64'(d0 + 1));
      @(posedge clk); #1;
    end

    // Address wrap.
    stim_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    build_exp(16'hFFFF, 8);
    chk("pin_wrap", {exp_q[0].a, exp_q[1].a}, {16'hFFFF, 16'h0000});
    run_layer(16'hFFFF, 8, 1'b0);

    // Spurious start after two samples is ignored.
    stim_q = '{8'h01, 8'h80, 8'h7E, 8'hC3, 8'h5A, 8'hA5, 8'h00, 8'hFF};
    build_exp(16'h0400, 8);
    run_layer(16'h0400, 8, 1'b1);

    // Reset mid-layer, then a clean num=4 layer.
    stim_q = '{8'h99, 8'h98, 8'h97, 8'h96, 8'h95, 8'h94, 8'h93, 8'h92};
    do_start(16'h0300, 16'd8);
    feed(3, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("reset_async",
        {ofm_ready, mem_wr_en, mem_wr_addr, mem_wr_data, mem_wr_be, busy, done}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    stim_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    build_exp(16'h0040, 4);
    chk("pin_after_reset", {exp_q[0].a, exp_q[0].d, exp_q[0].be}, {16'h0040, 32'hD4C3B2A1, 4'hF});
    run_layer(16'h0040, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
